// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the modulo up/down counter.
// The optional assertion set is enabled with MOD_COUNTER_SVA_EN.
package mod_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned WIDTH_DEFAULT = 8;

endpackage

// File: rtl/mod_counter_sva.sv
// Property set for mod_counter; bound in only when MOD_COUNTER_SVA_EN is defined.
`ifdef MOD_COUNTER_SVA_EN
module mod_counter_sva
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  input logic             en,
  input logic             up,
  input logic             sat,
  input logic             load,
  input logic [WIDTH-1:0] max_count,
  input logic             ovf_clr,
  input logic [WIDTH-1:0] q,
  input logic             tc,
  input logic             ovf,
  input logic             bnd
);

  logic step;
  assign step = !rst && !load && en;

  a_reset: assert property (@(posedge clk) rst |=> (q == '0 && !tc && !ovf));

  a_up_step: assert property (@(posedge clk)
    step && up && q < max_count |=> q == $past(q) + WIDTH'(1));

  a_down_step: assert property (@(posedge clk)
    step && !up && q != '0 && q <= max_count |=> q == $past(q) - WIDTH'(1));

  a_up_bound: assert property (@(posedge clk)
    step && up && q >= max_count |=> q == ($past(sat) ? $past(max_count) : '0));

  a_down_bound: assert property (@(posedge clk)
    step && !up && q == '0 |=> q == ($past(sat) ? '0 : $past(max_count)));

  a_tc_cause: assert property (@(posedge clk) tc |-> $past(bnd && !rst));

  a_ovf_sticky: assert property (@(posedge clk)
    ovf && !ovf_clr && !rst |=> ovf);

  a_load_clamp: assert property (@(posedge clk)
    !rst && load |=> q <= $past(max_count));

  c_up_wrap: cover property (@(posedge clk) step && up && !sat && bnd);
  c_down_wrap: cover property (@(posedge clk) step && !up && !sat && bnd);

endmodule
`endif

// File: rtl/mod_counter.sv
// Modulo up/down counter with wrap/saturate, load, tc pulse and sticky ovf.
// Define MOD_COUNTER_SVA_EN to compile in the mod_counter_sva property set.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_count,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             bnd;
  mode_e            mode;
  dir_e             dir;

  assign mode = mode_e'(sat);
  assign dir  = dir_e'(up);

  always_comb begin
    q_d = q_q;
    bnd = 1'b0;
    if (load) begin
      q_d = (load_val > max_count) ? max_count : load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (q_q < max_count) begin
          q_d = q_q + WIDTH'(1);
        end else begin
          bnd = 1'b1;
          q_d = (mode == MODE_SAT) ? max_count : '0;
        end
      end else begin
        // A modulus lowered below Q snaps back into range without an event.
        if (q_q > max_count) begin
          q_d = max_count;
        end else if (q_q == '0) begin
          bnd = 1'b1;
          q_d = (mode == MODE_SAT) ? '0 : max_count;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
    tc_d  = bnd;
    ovf_d = bnd | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

`ifdef MOD_COUNTER_SVA_EN
  mod_counter_sva #(.WIDTH(WIDTH)) u_sva (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .sat       (sat),
    .load      (load),
    .max_count (max_count),
    .ovf_clr   (ovf_clr),
    .q         (q_q),
    .tc        (tc_q),
    .ovf       (ovf_q),
    .bnd       (bnd)
  );
`else
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH = 8): directed vector table,
// a saturation burst and randomized traffic against an arithmetic model.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, sat, load, ovf_clr;
  logic [7:0] load_val, max_count;
  logic [7:0] q;
  logic       tc, ovf;

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .sat       (sat),
    .load      (load),
    .load_val  (load_val),
    .max_count (max_count),
    .ovf_clr   (ovf_clr),
    .Q         (q),
    .tc        (tc),
    .ovf       (ovf)
  );

  typedef struct {
    bit       rst;
    bit       load;
    bit [7:0] lv;
    bit       en;
    bit       up;
    bit       sat;
    bit [7:0] mx;
    bit       clr;
    int       exp_q;
    int       exp_tc;
    int       exp_ovf;
    string    name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string nm, input bit r, input bit ld, input int lv,
                              input bit e, input bit u, input bit s, input int mx,
                              input bit c, input int eq, input int etc, input int eovf);
    vec_t v;
    v.name = nm; v.rst = r; v.load = ld; v.lv = lv[7:0]; v.en = e; v.up = u;
    v.sat = s; v.mx = mx[7:0]; v.clr = c;
    v.exp_q = eq; v.exp_tc = etc; v.exp_ovf = eovf;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic drive(input bit r, input bit ld, input int lv, input bit e,
                       input bit u, input bit s, input int mx, input bit c);
    rst = r; load = ld; load_val = lv[7:0]; en = e; up = u; sat = s;
    max_count = mx[7:0]; ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic from the counter's rules.
  int m_q, m_tc, m_ovf;

  function automatic void model_step(input bit r, input bit ld, input int lv, input bit e,
                                     input bit u, input bit s, input int mx, input bit c);
    int ev;
    ev = 0;
    if (r) begin
      m_q = 0; m_tc = 0; m_ovf = 0;
      return;
    end
    if (ld) m_q = (lv < mx) ? lv : mx;
    else if (e && u) begin
      if (m_q >= mx) begin ev = 1; m_q = s ? mx : 0; end
      else m_q = m_q + 1;
    end else if (e) begin
      if (m_q > mx) m_q = mx;
      else if (m_q == 0) begin ev = 1; m_q = s ? 0 : mx; end
      else m_q = m_q - 1;
    end
    m_tc  = ev;
    m_ovf = (ev != 0 || (m_ovf != 0 && !c)) ? 1 : 0;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; ovf_clr = 1'b0;
    load_val = '0; max_count = '0;

    //   name         rst ld  lv  en up sat mx  clr   q  tc ovf
    add("reset",       1, 0,   0, 0, 1, 0,  5, 0,    0, 0, 0);
    for (int i = 1; i <= 5; i++)
      add("upwrap_cnt", 0, 0,  0, 1, 1, 0,  5, 0,    i, 0, 0);
    add("upwrap_wrap", 0, 0,   0, 1, 1, 0,  5, 0,    0, 1, 1);
    add("upwrap_next", 0, 0,   0, 1, 1, 0,  5, 0,    1, 0, 1);
    add("dsat_load",   0, 1,   2, 0, 0, 1,  5, 0,    2, 0, 1);
    add("dsat_1",      0, 0,   0, 1, 0, 1,  5, 0,    1, 0, 1);
    add("dsat_0",      0, 0,   0, 1, 0, 1,  5, 0,    0, 0, 1);
    add("dsat_hold0",  0, 0,   0, 1, 0, 1,  5, 0,    0, 1, 1);
    add("dsat_hold0b", 0, 0,   0, 1, 0, 1,  5, 0,    0, 1, 1);
    add("ovf_clear",   0, 0,   0, 0, 0, 1,  5, 1,    0, 0, 0);
    add("load_clamp",  0, 1, 200, 1, 1, 0, 10, 0,   10, 0, 0);
    add("clamp_wrap",  0, 0,   0, 1, 1, 0, 10, 0,    0, 1, 1);
    add("load9_clr",   0, 1,   9, 0, 1, 0, 10, 1,    9, 0, 0);
    add("mod_lowered", 0, 0,   0, 1, 0, 0,  4, 0,    4, 0, 0);
    add("sat_at_max",  0, 0,   0, 1, 1, 1,  4, 0,    4, 1, 1);
    add("ovf_race",    0, 0,   0, 1, 1, 1,  4, 1,    4, 1, 1);
    add("ovf_clr_only",0, 0,   0, 0, 1, 1,  4, 1,    4, 0, 0);
    add("rst_pre_ld",  0, 1,   3, 0, 1, 0,  3, 0,    3, 0, 0);
    add("rst_pre_wr",  0, 0,   0, 1, 1, 0,  3, 0,    0, 1, 1);
    add("rst_pre_1",   0, 0,   0, 1, 1, 0,  3, 0,    1, 0, 1);
    add("rst_pre_2",   0, 0,   0, 1, 1, 0,  3, 0,    2, 0, 1);
    add("rst_pre_3",   0, 0,   0, 1, 1, 0,  3, 0,    3, 0, 1);
    add("rst_mid",     1, 0,   0, 1, 1, 0,  3, 0,    0, 0, 0);
    add("rst_resume",  0, 0,   0, 1, 1, 0,  3, 0,    1, 0, 0);
    add("max0_up",     0, 0,   0, 1, 1, 0,  0, 0,    0, 1, 1);
    add("max0_down",   0, 0,   0, 1, 0, 1,  0, 0,    0, 1, 1);
    add("full_load",   0, 1, 255, 0, 1, 0,255, 1,  255, 0, 0);
    add("full_roll",   0, 0,   0, 1, 1, 0,255, 0,    0, 1, 1);
    add("full_unroll", 0, 0,   0, 1, 0, 0,255, 0,  255, 1, 1);
    add("down_plain",  0, 0,   0, 1, 0, 0,255, 0,  254, 0, 1);
    add("hold",        0, 0,   0, 0, 0, 0,255, 0,  254, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].load, int'(tbl[i].lv), tbl[i].en, tbl[i].up,
            tbl[i].sat, int'(tbl[i].mx), tbl[i].clr);
      chk({tbl[i].name, ".Q"},   int'(q),   tbl[i].exp_q);
      chk({tbl[i].name, ".tc"},  int'(tc),  tbl[i].exp_tc);
      chk({tbl[i].name, ".ovf"}, int'(ovf), tbl[i].exp_ovf);
    end

    // Continuous saturation at the top: tc stays high every cycle.
    drive(0, 1, 7, 0, 1, 1, 7, 1);
    chk("satburst_load.Q", int'(q), 7);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 1, 7, 0);
      chk("satburst.Q", int'(q), 7);
      chk("satburst.tc", int'(tc), 1);
    end
    drive(0, 0, 0, 0, 1, 1, 7, 0);
    chk("satburst_end.tc", int'(tc), 0);
    chk("satburst_end.ovf", int'(ovf), 1);

    // Randomized traffic against the reference model.
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit r, ld, e, u, s, c;
      int lv, mx;
      r  = ($urandom_range(39) == 0);
      ld = ($urandom_range(7) == 0);
      e  = ($urandom_range(3) != 0);
      u  = $urandom_range(1);
      s  = $urandom_range(1);
      c  = ($urandom_range(5) == 0);
      lv = $urandom_range(255);
      case ($urandom_range(3))
        0:       mx = $urandom_range(3);
        1:       mx = 255;
        default: mx = $urandom_range(12);
      endcase
      model_step(r, ld, lv, e, u, s, mx, c);
      drive(r, ld, lv, e, u, s, mx, c);
      chk("rand.Q",   int'(q),   m_q);
      chk("rand.tc",  int'(tc),  m_tc);
      chk("rand.ovf", int'(ovf), m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
